captura_lectura_vga: RTL and testbench

Downstream consumer of the RTC read stage: captures each byte that stage delivers on `data_vga`, qualified by the one-hot register strobe `band_dir_vga`, into a shadow bank. It commits a coherent nine-register time/date/timer snapshot to the VGA text generator only when a full read sweep completes cleanly. Incomplete, malformed or timed-out sweeps are discarded, so the display never shows a torn or corrupted time.

---
 rtl/captura_lectura_vga.sv | 188 ++++++++++++++++++
 tb/tb_captura_lectura_vga.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_lectura_vga.sv
// captura_lectura_vga
// Captures the RTC read-stage bytes into a shadow bank and commits a coherent
// nine-register snapshot to the VGA text generator only when a whole sweep
// arrives complete, one-hot and on time.  Rejected sweeps leave the snapshot
// untouched and bump a saturating error counter.
//
// Optional feature macro: BCD_RANGE_CHECK_EN (adds a BCD/range check at commit).
//
// Ports:
//   clk, reset            clock, async active-high reset
//   data_vga[7:0]         BCD byte, qualified by band_dir_vga
//   band_dir_vga[8:0]     one-hot register strobe (seg,min,hora,dia,mes,anio,tseg,tmin,thora)
//   band_z                end-of-sweep pulse
//   *_vga[7:0]            committed snapshot
//   act_vga               one-clk pulse on commit
//   valido                set by first commit, cleared by reset
//   err                   one-clk pulse on rejected sweep
//   err_cnt[7:0]          saturating reject count
//
// state   | meaning
// IDLE    | no sweep in progress
// COLLECT | sweep in progress, timeout running
// COMMIT  | evaluate the sweep, publish or reject

module captura_lectura_vga #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_vga,
    input  logic [8:0] band_dir_vga,
    input  logic       band_z,
    output logic [7:0] seg_vga,
    output logic [7:0] min_vga,
    output logic [7:0] hora_vga,
    output logic [7:0] dia_vga,
    output logic [7:0] mes_vga,
    output logic [7:0] anio_vga,
    output logic [7:0] tseg_vga,
    output logic [7:0] tmin_vga,
    output logic [7:0] thora_vga,
    output logic       act_vga,
    output logic       valido,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    // Loaded with TIMEOUT_CYC-1 so that TIMEOUT_CYC strobe-free cycles reach
    // the terminal count and err shows up in the cycle after.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shadow_q [9];
    logic [7:0]    snap_q   [9];
    logic [8:0]    mask_q;
    logic          bad_q;
    logic [TW-1:0] tmr_q;

    logic strobe_one, strobe_multi;
    logic cap, set_bad, load, dec, clear, accept, reject;
    logic range_ok, sweep_ok;

    assign strobe_one   = (band_dir_vga != 9'd0) &&
                          ((band_dir_vga & (band_dir_vga - 9'd1)) == 9'd0);
    assign strobe_multi = (band_dir_vga != 9'd0) && !strobe_one;

`ifdef BCD_RANGE_CHECK_EN
    // Valid BCD orders the same as its hex encoding, so bounds compare directly.
    function automatic logic bcd_in(input logic [7:0] v, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
    endfunction

    always_comb begin
        range_ok = bcd_in(shadow_q[0], 8'h00, 8'h59) &&
                   bcd_in(shadow_q[1], 8'h00, 8'h59) &&
                   bcd_in(shadow_q[2], 8'h00, 8'h23) &&
                   bcd_in(shadow_q[3], 8'h01, 8'h31) &&
                   bcd_in(shadow_q[4], 8'h01, 8'h12) &&
                   bcd_in(shadow_q[5], 8'h00, 8'h99) &&
                   bcd_in(shadow_q[6], 8'h00, 8'h59) &&
                   bcd_in(shadow_q[7], 8'h00, 8'h59) &&
                   bcd_in(shadow_q[8], 8'h00, 8'h23);
    end
`else
    assign range_ok = 1'b1;
`endif

    assign sweep_ok = (mask_q == 9'h1FF) && !bad_q && range_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        set_bad = 1'b0;
        load    = 1'b0;
        dec     = 1'b0;
        clear   = 1'b0;
        accept  = 1'b0;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe_one || strobe_multi) begin
                    cap     = strobe_one;
                    set_bad = strobe_multi;
                    load    = 1'b1;
                    state_d = band_z ? COMMIT : COLLECT;
                end
            end
            COLLECT: begin
                cap     = strobe_one;
                set_bad = strobe_multi;
                load    = strobe_one;
                dec     = !strobe_one && (tmr_q != '0);
                if (band_z) begin
                    state_d = COMMIT;
                end else if (!strobe_one && (tmr_q == '0)) begin
                    set_bad = 1'b0;
                    reject  = 1'b1;
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                clear  = 1'b1;
                accept = sweep_ok;
                reject = !sweep_ok;
                // A strobe here opens the next sweep on top of the cleared mask.
                if (strobe_one || strobe_multi) begin
                    cap     = strobe_one;
                    set_bad = strobe_multi;
                    load    = 1'b1;
                    state_d = COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= 8'h00;
                snap_q[i]   <= 8'h00;
            end
            mask_q  <= 9'd0;
            bad_q   <= 1'b0;
            tmr_q   <= '0;
            act_vga <= 1'b0;
            err     <= 1'b0;
            valido  <= 1'b0;
            err_cnt <= 8'h00;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (cap && band_dir_vga[i]) shadow_q[i] <= data_vga;
                if (accept)                 snap_q[i]   <= shadow_q[i];
            end
            mask_q <= (clear ? 9'd0 : mask_q) | (cap ? band_dir_vga : 9'd0);
            bad_q  <= (clear ? 1'b0 : bad_q) | set_bad;
            if (load)     tmr_q <= TMR_LOAD;
            else if (dec) tmr_q <= tmr_q - 1'b1;
            act_vga <= accept;
            err     <= reject;
            if (accept) valido <= 1'b1;
            if (reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign seg_vga   = snap_q[0];
    assign min_vga   = snap_q[1];
    assign hora_vga  = snap_q[2];
    assign dia_vga   = snap_q[3];
    assign mes_vga   = snap_q[4];
    assign anio_vga  = snap_q[5];
    assign tseg_vga  = snap_q[6];
    assign tmin_vga  = snap_q[7];
    assign thora_vga = snap_q[8];

endmodule

// File: tb/tb_captura_lectura_vga.sv
module tb_captura_lectura_vga;

    localparam int TO = 16;
`ifdef BCD_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_vga;
    logic [8:0] band_dir_vga;
    logic       band_z;
    logic [7:0] seg_vga, min_vga, hora_vga, dia_vga, mes_vga, anio_vga;
    logic [7:0] tseg_vga, tmin_vga, thora_vga, err_cnt;
    logic       act_vga, valido, err;
    logic [7:0] outs [9];

    captura_lectura_vga #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .data_vga(data_vga), .band_dir_vga(band_dir_vga),
        .band_z(band_z), .seg_vga(seg_vga), .min_vga(min_vga), .hora_vga(hora_vga),
        .dia_vga(dia_vga), .mes_vga(mes_vga), .anio_vga(anio_vga), .tseg_vga(tseg_vga),
        .tmin_vga(tmin_vga), .thora_vga(thora_vga), .act_vga(act_vga), .valido(valido),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        outs[0] = seg_vga;  outs[1] = min_vga;  outs[2] = hora_vga;
        outs[3] = dia_vga;  outs[4] = mes_vga;  outs[5] = anio_vga;
        outs[6] = tseg_vga; outs[7] = tmin_vga; outs[8] = thora_vga;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
        end
    endtask

    // ---------------- reference model (sweep-level) ----------------
    logic [7:0] m_sh   [9];
    logic [7:0] m_snap [9];
    bit   [8:0] m_mask;
    bit         m_bad;
    int         m_cnt;
    bit         m_valido;
    int         minv [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    int         maxv [9] = '{59, 59, 23, 31, 12, 99, 59, 59, 23};

    function automatic void m_reset();
        for (int i = 0; i < 9; i++) begin m_sh[i] = 0; m_snap[i] = 0; end
        m_mask = 0; m_bad = 0; m_cnt = 0; m_valido = 0;
    endfunction

    function automatic void m_strobe(input logic [8:0] b, input logic [7:0] d);
        if ($countones(b) == 1) begin
            for (int i = 0; i < 9; i++)
                if (b[i]) begin m_sh[i] = d; m_mask[i] = 1'b1; end
        end else if ($countones(b) > 1) begin
            m_bad = 1'b1;
        end
    endfunction

    function automatic bit m_range();
        if (!RC) return 1'b1;
        for (int i = 0; i < 9; i++) begin
            int hi, lo, n;
            hi = int'(m_sh[i][7:4]);
            lo = int'(m_sh[i][3:0]);
            if (hi > 9 || lo > 9) return 1'b0;
            n = hi * 10 + lo;
            if (n < minv[i] || n > maxv[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_reject();
        if (m_cnt < 255) m_cnt++;
        m_mask = 0; m_bad = 0;
    endfunction

    function automatic bit m_commit();
        bit acc;
        acc = (m_mask == 9'h1FF) && !m_bad && m_range();
        if (acc) begin
            for (int i = 0; i < 9; i++) m_snap[i] = m_sh[i];
            m_valido = 1'b1;
            m_mask = 0; m_bad = 0;
        end else begin
            m_reject();
        end
        return acc;
    endfunction

    task automatic check_state(input string tag, input bit exp_act, input bit exp_err);
        chk({tag, ".act"}, 32'(act_vga), 32'(exp_act));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
        chk({tag, ".valido"}, 32'(valido), 32'(m_valido));
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s.snap%0d", tag, i), 32'(outs[i]), 32'(m_snap[i]));
    endtask

    // ---------------- drivers: each task owns exactly one clock cycle -------------
    task automatic strobe(input logic [8:0] b, input logic [7:0] d);
        @(posedge clk); #1;
        band_dir_vga = b; data_vga = d; band_z = 1'b0;
        m_strobe(b, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            band_dir_vga = 9'd0; band_z = 1'b0;
        end
    endtask

    // band_z cycle (optionally with a last strobe), then the COMMIT cycle
    // (optionally with a strobe opening the next sweep), then check.
    task automatic end_sweep(input string tag, input logic [8:0] lb, input logic [7:0] ld,
                             input logic [8:0] cb, input logic [7:0] cd);
        bit acc;
        @(posedge clk); #1;
        band_dir_vga = lb; data_vga = ld; band_z = 1'b1;
        m_strobe(lb, ld);
        @(posedge clk); #1;
        band_dir_vga = cb; data_vga = cd; band_z = 1'b0;
        acc = m_commit();
        m_strobe(cb, cd);
        @(posedge clk); #1;
        band_dir_vga = 9'd0; band_z = 1'b0;
        @(negedge clk);
        check_state(tag, acc, !acc);
    endtask

    typedef struct {
        logic [7:0] d [9];
        logic [8:0] skip;
        bit         ovl;
        bit         exp_act;
        logic [7:0] exp_seg;
    } row_t;

    row_t       rows [6];
    logic [7:0] base [9] = '{8'h45, 8'h30, 8'h12, 8'h18, 8'h05, 8'h16, 8'h10, 8'h02, 8'h00};

    task automatic base_strobes(input int upto);
        for (int i = 0; i < upto; i++) strobe(9'b1 << i, base[i]);
    endtask

    function automatic logic [7:0] rnd_val(input int i);
        int n;
        if ($urandom_range(7) == 0) return 8'($urandom);
        n = int'($urandom_range(maxv[i], minv[i]));
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        int k;
        bit seen;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) rows[r].d[i] = base[i];
            rows[r].skip = 9'd0; rows[r].ovl = 1'b0;
        end
        rows[0].exp_act = 1'b1; rows[0].exp_seg = 8'h45;
        rows[1].skip = 9'h100; rows[1].exp_act = 1'b0; rows[1].exp_seg = 8'h45;
        rows[2].ovl = 1'b1;    rows[2].exp_act = 1'b0; rows[2].exp_seg = 8'h45;
        rows[3].d[0] = 8'h11; rows[3].d[2] = 8'h07;
        rows[3].exp_act = 1'b1; rows[3].exp_seg = 8'h11;
        rows[4].d[0] = 8'h22; rows[4].d[1] = 8'h60;
        rows[4].exp_act = !RC; rows[4].exp_seg = RC ? 8'h11 : 8'h22;
        rows[5].d[0] = 8'h33; rows[5].d[4] = 8'h00;
        rows[5].exp_act = !RC; rows[5].exp_seg = RC ? 8'h11 : 8'h33;

        reset = 1'b1; data_vga = 8'h00; band_dir_vga = 9'd0; band_z = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("reset", 1'b0, 1'b0);
        #1 reset = 1'b0;

        // table-driven sweeps
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) begin
                if (!rows[r].skip[i]) strobe(9'b1 << i, rows[r].d[i]);
                if (rows[r].ovl && i == 4) strobe(9'h003, 8'hAA);
            end
            end_sweep($sformatf("row%0d", r), 9'd0, 8'h00, 9'd0, 8'h00);
            chk($sformatf("row%0d.tbl_act", r), 32'(act_vga), 32'(rows[r].exp_act));
            chk($sformatf("row%0d.tbl_seg", r), 32'(seg_vga), 32'(rows[r].exp_seg));
            if (r == 0) begin
                idle(1);
                @(negedge clk);
                chk("row0.act_pulse_end", 32'(act_vga), 32'd0);
                chk("row0.valido_hold", 32'(valido), 32'd1);
            end
        end

        // repeat: last value wins
        strobe(9'h001, 8'h10);
        strobe(9'h001, 8'h11);
        for (int i = 1; i < 9; i++) strobe(9'b1 << i, base[i]);
        end_sweep("repeat", 9'd0, 8'h00, 9'd0, 8'h00);
        chk("repeat.seg", 32'(seg_vga), 32'h11);

        // strobe in COMMIT cycle opens the next sweep
        base_strobes(9);
        end_sweep("commit_strobe.a", 9'd0, 8'h00, 9'h001, 8'h33);
        for (int i = 1; i < 9; i++) strobe(9'b1 << i, base[i]);
        end_sweep("commit_strobe.b", 9'd0, 8'h00, 9'd0, 8'h00);
        chk("commit_strobe.seg", 32'(seg_vga), 32'h33);

        // timeout: err expected 17 cycles after the last strobe
        idle(2);
        base_strobes(3);
        k = 0; seen = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            idle(1);
            @(negedge clk);
            if (err) begin seen = 1; k = c; end
        end
        chk("timeout.seen", 32'(seen), 32'd1);
        chk("timeout.cycle", 32'(k), 32'(TO + 1));
        m_reject();
        chk("timeout.err_cnt", 32'(err_cnt), 32'(m_cnt));
        base_strobes(9);
        end_sweep("after_timeout", 9'd0, 8'h00, 9'd0, 8'h00);

        // reset mid-sweep after a prior commit
        base_strobes(2);
        @(posedge clk); #1;
        band_dir_vga = 9'd0;
        #2 reset = 1'b1;
        m_reset();
        #2;
        check_state("mid_reset", 1'b0, 1'b0);
        chk("mid_reset.valido", 32'(valido), 32'd0);
        #1 reset = 1'b0;

        // last byte together with band_z
        base_strobes(8);
        end_sweep("same_cycle", 9'h100, 8'h09, 9'd0, 8'h00);
        chk("same_cycle.thora", 32'(thora_vga), 32'h09);
        chk("same_cycle.act", 32'(act_vga), 32'd1);

        // band_z alone in IDLE is ignored
        idle(1);
        @(posedge clk); #1 band_z = 1'b1;
        @(posedge clk); #1 band_z = 1'b0;
        @(negedge clk);
        chk("z_idle.err1", 32'(err), 32'd0);
        idle(1);
        @(negedge clk);
        check_state("z_idle", 1'b0, 1'b0);

        // randomized sweeps against the model
        for (int s = 0; s < 40; s++) begin
            logic [8:0] evb [$];
            logic [7:0] evd [$];
            logic [8:0] drop;
            bit lastz;
            drop = ($urandom_range(4) == 0) ? (9'b1 << $urandom_range(8)) : 9'd0;
            for (int i = 0; i < 9; i++) begin
                if (drop[i]) continue;
                if ($urandom_range(5) == 0) begin evb.push_back(9'b1 << i); evd.push_back(8'($urandom)); end
                evb.push_back(9'b1 << i); evd.push_back(rnd_val(i));
            end
            if ($urandom_range(7) == 0) begin evb.insert(1, 9'h0C0); evd.insert(1, 8'h77); end
            lastz = ($urandom_range(2) == 0);
            for (int e = 0; e < evb.size(); e++) begin
                if (lastz && e == evb.size() - 1) begin
                    end_sweep($sformatf("rnd%0d", s), evb[e], evd[e], 9'd0, 8'h00);
                end else begin
                    strobe(evb[e], evd[e]);
                    idle(int'($urandom_range(2)));
                end
            end
            if (!lastz) end_sweep($sformatf("rnd%0d", s), 9'd0, 8'h00, 9'd0, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
